// File: rtl/adrv9001_spi_responder.sv
// SPI responder for the ADRV9001 control-port frame: a 16-bit instruction
// followed by 8-bit data bytes, decoded onto a simple register bus.
// All SPI pins are oversampled in the system clock domain.
module adrv9001_spi_responder #(
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2,
  parameter int STREAM_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_csn,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              abort
);

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    csn_prev_q, csn_prev_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [14:0]             sh_q, sh_d;
  logic [7:0]              tx_q, tx_d;
  logic                    rw_q, rw_d;
  logic [ADDR_W-1:0]       reg_addr_q, reg_addr_d;
  logic [7:0]              reg_wdata_q, reg_wdata_d;
  logic                    reg_wr_q, reg_wr_d;
  logic                    reg_rd_q, reg_rd_d;
  logic                    abort_q, abort_d;

  logic                    sclk_s, csn_s, mosi_s;
  logic                    sclk_rise, sclk_fall, csn_fall;
  logic                    byte_done;
  logic [14:0]             addr15;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign addr15    = {sh_q[13:0], mosi_s};
  assign byte_done = sclk_rise && (cnt_q == 4'd7);

  // Synchronizer chains and the registered copies used for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    csn_prev_d  = csn_s;
  end

  // Frame decoder: next state, shift registers, bus strobes and abort
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    abort_d     = 1'b0;

    // Read data arrives one clk after the read strobe; otherwise shift out
    // on sclk falls, except the first fall of each byte so bit 7 is held.
    if (reg_rd_q) begin
      tx_d = reg_rdata;
    end else if (state_q == DATA && rw_q && sclk_fall && cnt_q != 4'd0) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    // A streamed write moves to the next address once its strobe is out,
    // so reg_addr stays valid alongside reg_wr.
    if (reg_wr_q && state_q == DATA && STREAM_EN != 0) begin
      reg_addr_d = reg_addr_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (csn_fall) begin
          cnt_d   = 4'd0;
          state_d = INSTR;
        end
      end

      INSTR: begin
        if (csn_s) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          sh_d = {sh_q[13:0], mosi_s};
          if (cnt_q == 4'd15) begin
            rw_d       = sh_q[14];
            reg_addr_d = addr15[ADDR_W-1:0];
            reg_rd_d   = sh_q[14];
            cnt_d      = 4'd0;
            state_d    = DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (sclk_rise) begin
          sh_d = {sh_q[13:0], mosi_s};
        end
        if (byte_done) begin
          cnt_d = 4'd0;
          if (!rw_q) begin
            reg_wdata_d = {sh_q[6:0], mosi_s};
            reg_wr_d    = 1'b1;
          end
          if (csn_s) begin
            state_d = IDLE;
          end else if (STREAM_EN != 0) begin
            if (rw_q) begin
              reg_addr_d = reg_addr_q + ADDR_W'(1);
              reg_rd_d   = 1'b1;
            end
          end else begin
            state_d = HOLD;
          end
        end else if (csn_s) begin
          abort_d = (cnt_q != 4'd0);
          state_d = IDLE;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      HOLD: begin
        if (csn_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      cnt_q       <= 4'd0;
      sh_q        <= '0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      csn_prev_q  <= csn_prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      abort_q     <= abort_d;
    end
  end

  assign spi_miso_oe = (state_q == DATA) && rw_q;
  assign spi_miso    = spi_miso_oe & tx_q[7];
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign busy        = ~csn_s;
  assign abort       = abort_q;

endmodule

// File: tb/tb_adrv9001_spi_responder.sv
// Self-checking bench for adrv9001_spi_responder: an SPI master drives
// frames while a bus monitor pops expected strobes from scoreboard queues.
module tb_adrv9001_spi_responder;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_csn = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [14:0] reg_addr;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic        reg_rd;
  logic [7:0]  reg_rdata = 8'h00;
  logic        busy;
  logic        abort;

  int checks = 0;
  int failures = 0;
  int abort_cnt = 0;

  logic [14:0] exp_wr_addr[$];
  logic [7:0]  exp_wr_data[$];
  logic [14:0] exp_rd_addr[$];
  logic [14:0] pop_addr;
  logic [7:0]  pop_data;

  adrv9001_spi_responder #(
    .ADDR_W(15),
    .SYNC_STAGES(2),
    .STREAM_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_csn(spi_csn),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr),
    .reg_wr(reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata),
    .busy(busy),
    .abort(abort)
  );

  // 100 MHz-style system clock, ten times the SPI clock
  always #5 clk = ~clk;

  // Bus monitor: every strobe must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) begin
        checks++;
        if (exp_wr_addr.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_wr actual addr=%h data=%h required no write", reg_addr, reg_wdata);
        end else begin
          pop_addr = exp_wr_addr.pop_front();
          pop_data = exp_wr_data.pop_front();
          if (reg_addr !== pop_addr || reg_wdata !== pop_data) begin
            failures++;
            $display("[TB] FAIL wr_txn actual addr=%h data=%h required addr=%h data=%h",
                     reg_addr, reg_wdata, pop_addr, pop_data);
          end
        end
      end
      if (reg_rd) begin
        checks++;
        if (exp_rd_addr.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_rd actual addr=%h required no read", reg_addr);
        end else begin
          pop_addr = exp_rd_addr.pop_front();
          if (reg_addr !== pop_addr) begin
            failures++;
            $display("[TB] FAIL rd_addr actual=%h required=%h", reg_addr, pop_addr);
          end
        end
      end
      if (abort) abort_cnt++;
    end
  end

  // Watchdog so the run always ends even if the stimulus stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_bit(input logic b, output logic miso_s, output logic oe_s);
    spi_mosi = b;
    #HALF;
    miso_s = spi_miso;
    oe_s = spi_miso_oe;
    spi_sclk = 1'b1;
    #HALF;
    spi_sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [31:0] v, input int n, output logic [31:0] cap,
                          output logic oe_instr_any, output logic oe_data_all);
    logic m;
    logic o;
    cap = '0;
    oe_instr_any = 1'b0;
    oe_data_all = 1'b1;
    spi_csn = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_bit(v[31-i], m, o);
      cap = {cap[30:0], m};
      if (i < 16 && o) oe_instr_any = 1'b1;
      if (i >= 16 && !o) oe_data_all = 1'b0;
    end
    #HALF;
    spi_csn = 1'b1;
    spi_mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (spi_miso !== 1'b0 || spi_miso_oe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_miso actual miso=%b oe=%b required 0 0", spi_miso, spi_miso_oe);
    end
    checks++;
    if (reg_addr !== 15'h0 || reg_wdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_bus actual addr=%h wdata=%h required 0 0", reg_addr, reg_wdata);
    end
    checks++;
    if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes actual wr=%b rd=%b required 0 0", reg_wr, reg_rd);
    end
    checks++;
    if (busy !== 1'b0 || abort !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_status actual busy=%b abort=%b required 0 0", busy, abort);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write;
    logic [31:0] cap;
    logic oi, od;
    int ab0;
    ab0 = abort_cnt;
    exp_wr_addr.push_back(15'h0012);
    exp_wr_data.push_back(8'hA5);
    spi_xfer({1'b0, 15'h0012, 8'hA5, 8'h00}, 24, cap, oi, od);
    checks++;
    if (exp_wr_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL write_missing actual pending=%0d required 0", exp_wr_addr.size());
      exp_wr_addr.delete();
      exp_wr_data.delete();
    end
    checks++;
    if (abort_cnt - ab0 !== 0) begin
      failures++;
      $display("[TB] FAIL write_abort actual=%0d required=0", abort_cnt - ab0);
    end
    checks++;
    if (oi !== 1'b0 || od !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_oe actual instr=%b data=%b required 0 0", oi, od);
    end
  endtask

  task automatic test_read;
    logic [31:0] cap;
    logic oi, od;
    int ab0;
    ab0 = abort_cnt;
    reg_rdata = 8'h3C;
    exp_rd_addr.push_back(15'h0105);
    exp_rd_addr.push_back(15'h0106);
    spi_xfer({1'b1, 15'h0105, 8'h00, 8'h00}, 24, cap, oi, od);
    checks++;
    if (cap[7:0] !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL read_data actual=%h required=3c", cap[7:0]);
    end
    checks++;
    if (oi !== 1'b0 || od !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_oe actual instr=%b data=%b required 0 1", oi, od);
    end
    checks++;
    if (spi_miso_oe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_oe_after actual=%b required=0", spi_miso_oe);
    end
    checks++;
    if (exp_rd_addr.size() !== 0 || abort_cnt - ab0 !== 0) begin
      failures++;
      $display("[TB] FAIL read_txn actual pending=%0d aborts=%0d required 0 0",
               exp_rd_addr.size(), abort_cnt - ab0);
      exp_rd_addr.delete();
    end
  endtask

  task automatic test_stream_wrap;
    logic [31:0] cap;
    logic oi, od;
    exp_wr_addr.push_back(15'h7FFF);
    exp_wr_data.push_back(8'h11);
    exp_wr_addr.push_back(15'h0000);
    exp_wr_data.push_back(8'h22);
    spi_xfer({1'b0, 15'h7FFF, 8'h11, 8'h22}, 32, cap, oi, od);
    checks++;
    if (exp_wr_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL stream_missing actual pending=%0d required 0", exp_wr_addr.size());
      exp_wr_addr.delete();
      exp_wr_data.delete();
    end
  endtask

  task automatic test_abort_instr;
    logic [31:0] cap;
    logic oi, od;
    int ab0;
    ab0 = abort_cnt;
    spi_xfer({1'b0, 15'h0001, 8'h55, 8'h00}, 10, cap, oi, od);
    checks++;
    if (abort_cnt - ab0 !== 1) begin
      failures++;
      $display("[TB] FAIL abort_instr_count actual=%0d required=1", abort_cnt - ab0);
    end
    exp_wr_addr.push_back(15'h0001);
    exp_wr_data.push_back(8'hFF);
    spi_xfer({1'b0, 15'h0001, 8'hFF, 8'h00}, 24, cap, oi, od);
    checks++;
    if (exp_wr_addr.size() !== 0 || abort_cnt - ab0 !== 1) begin
      failures++;
      $display("[TB] FAIL abort_instr_recover actual pending=%0d aborts=%0d required 0 1",
               exp_wr_addr.size(), abort_cnt - ab0);
      exp_wr_addr.delete();
      exp_wr_data.delete();
    end
  endtask

  task automatic test_abort_data;
    logic [31:0] cap;
    logic oi, od;
    int ab0;
    ab0 = abort_cnt;
    exp_wr_addr.push_back(15'h0040);
    exp_wr_data.push_back(8'hAB);
    spi_xfer({1'b0, 15'h0040, 8'hAB, 8'hCD}, 29, cap, oi, od);
    checks++;
    if (abort_cnt - ab0 !== 1) begin
      failures++;
      $display("[TB] FAIL abort_data_count actual=%0d required=1", abort_cnt - ab0);
    end
    checks++;
    if (exp_wr_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL abort_data_first actual pending=%0d required 0", exp_wr_addr.size());
      exp_wr_addr.delete();
      exp_wr_data.delete();
    end
  endtask

  task automatic test_reset_midread;
    logic [15:0] instr;
    logic [31:0] cap;
    logic m, o, oi, od;
    int ab0;
    reg_rdata = 8'h5A;
    instr = {1'b1, 15'h0020};
    exp_rd_addr.push_back(15'h0020);
    spi_csn = 1'b0;
    for (int i = 0; i < 16; i++) spi_bit(instr[15-i], m, o);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m, o);
    checks++;
    if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midread_pre actual busy=%b oe=%b required 1 1", busy, spi_miso_oe);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || reg_rd !== 1'b0 || reg_wr !== 1'b0 ||
        busy !== 1'b0 || abort !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midread_async actual oe=%b miso=%b rd=%b wr=%b busy=%b abort=%b required all 0",
               spi_miso_oe, spi_miso, reg_rd, reg_wr, busy, abort);
    end
    spi_csn = 1'b1;
    spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (exp_rd_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL midread_rd actual pending=%0d required 0", exp_rd_addr.size());
      exp_rd_addr.delete();
    end
    ab0 = abort_cnt;
    exp_wr_addr.push_back(15'h0033);
    exp_wr_data.push_back(8'h7E);
    spi_xfer({1'b0, 15'h0033, 8'h7E, 8'h00}, 24, cap, oi, od);
    checks++;
    if (exp_wr_addr.size() !== 0 || abort_cnt - ab0 !== 0) begin
      failures++;
      $display("[TB] FAIL midread_recover actual pending=%0d aborts=%0d required 0 0",
               exp_wr_addr.size(), abort_cnt - ab0);
      exp_wr_addr.delete();
      exp_wr_data.delete();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_stream_wrap();
    test_abort_instr();
    test_abort_data();
    test_reset_midread();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
